pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: DATA_W, 32, width of the data payload (register operands, immediates, register indices).
REQ-002 Parameter: CTRL_W, 9, width of the control payload (WB/M/EX control bits).
REQ-003 Parameter: CLR_DATA_ON_FLUSH, 0, when 1 the flush clears data_out to 0; when 0 data_out holds.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 Port: flush  input  1  synchronous kill of all held entries (bubble insertion on branch or hazard).
REQ-007 Port: in_valid  input  1  upstream holds a valid entry.
REQ-008 Port: in_ready  output  1  stage can accept an entry this cycle.
REQ-009 Port: ctrl_in  input  CTRL_W  control payload from upstream.
REQ-010 Port: data_in  input  DATA_W  data payload from upstream.
REQ-011 Port: out_valid  output  1  stage presents a valid entry.
REQ-012 Port: out_ready  input  1  downstream accepts; low means stall.
REQ-013 Port: ctrl_out  output  CTRL_W  control payload; 0 whenever out_valid=0.
REQ-014 Port: data_out  output  DATA_W  data payload of the presented entry.
REQ-015 Port: occ  output  2  entries held (0, 1 or 2).

Function
REQ-016 Storage: main register (drives outputs) plus one skid register; ctrl and data always travel together.
REQ-017 Input accept when in_valid=1 and in_ready=1; output transfer when out_valid=1 and out_ready=1.
REQ-018 in_ready = NOT skid_valid AND reset; it depends only on registered state and reset, never combinationally on out_ready.
REQ-019 Latency: an entry accepted into an empty stage appears on out_valid/ctrl_out/data_out on the next rising edge.
REQ-020 Throughput: with out_ready held 1, one entry per cycle, occ never exceeds 1.
REQ-021 Main empty or main transferring out: main loads the skid entry if skid_valid, else the accepted input, else becomes empty.
REQ-022 Main full and not transferring out while input accepted: the input goes to skid, occ becomes 2, in_ready falls next cycle.
REQ-023 Main and skid both full, out transfer: skid moves to main; the input is not accepted because in_ready=0; occ becomes 1.
REQ-024 Order preserved: entries leave in acceptance order; none dropped or duplicated except by flush or reset.
REQ-025 Main becoming empty: ctrl_out is 0 on that same edge; data_out holds its last value.
REQ-026 Flush=1 at an edge: main_valid and skid_valid cleared, occ=0, ctrl_out=0; any input accepted that cycle and any output transfer that cycle are still counted by both sides, but the input entry is discarded.
REQ-027 Flush data handling: data_out cleared to 0 only when CLR_DATA_ON_FLUSH=1.
REQ-028 Flush is level-sampled: flush held high for N cycles keeps the stage empty for N edges while in_ready stays 1.
REQ-029 occ counts held entries: 0 = none, 1 = main only, 2 = main and skid; the value 3 never occurs.
REQ-030 Priority at an edge: reset first, then flush, then normal transfer.

Reset
REQ-031 On a rising clk edge with reset=0, the following are cleared: out_valid=0, skid_valid=0, occ=0, ctrl_out=0, data_out=0, and all skid contents=0.
REQ-032 in_ready=0 while reset=0, and 1 in the first cycle after reset returns high.
REQ-033 reset=0 mid-operation discards both entries regardless of flush, in_valid or out_ready.
REQ-034 No state is modified asynchronously.

Verification
REQ-035 Streaming: out_ready=1, in_valid=1 for 8 cycles with data 1..8 -> data_out 1..8 on the following 8 cycles, occ=1, in_ready=1 throughout.
REQ-036 Stall fill: accept A=0x11, then out_ready=0 while offering B=0x22 and C=0x33 -> B goes to skid, occ=2, in_ready=0, C stays held upstream; on release, outputs are A, B, C in consecutive cycles.
REQ-037 Flush with occ=2 (ctrl_in=0x1FF) -> next cycle out_valid=0, ctrl_out=0, occ=0, in_ready=1; data_out holds when CLR=0 and is 0 when CLR=1.
REQ-038 Simultaneous flush and accept of D=0x44 -> D never appears; the next accepted entry E appears one cycle after its accept.
REQ-039 Reset=0 asserted with occ=2 and out_ready toggling -> after one edge all outputs are 0 and in_ready=0; one cycle after release, in_ready=1.
REQ-040 Random valid/ready/flush for 10k cycles checked against a scoreboard -> order is preserved, nothing is lost except flushed entries, occ is always 2 or less, and ctrl_out=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Elastic pipeline register (main + one skid entry) used between pipeline
//   stages. Control and data payloads always move together as one entry.
//   in_ready is derived only from registered state and reset, so the
//   upstream handshake never sees a combinational path from out_ready.
//
// Parameters
//   DATA_W            data payload width
//   CTRL_W            control payload width
//   CLR_DATA_ON_FLUSH 1: flush zeroes data_out, 0: data_out holds on flush
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   flush      in   synchronous kill of all held entries
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can take an entry this cycle
//   ctrl_in    in   upstream control payload
//   data_in    in   upstream data payload
//   out_valid  out  stage presents an entry
//   out_ready  in   downstream accepts (low = stall)
//   ctrl_out   out  control payload, forced 0 while out_valid=0
//   data_out   out  data payload of the presented entry
//   occ        out  number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W            = 32,
  parameter int CTRL_W            = 9,
  parameter int CLR_DATA_ON_FLUSH = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        occ
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t r_main;
  entry_t r_skid;
  logic   r_main_vld;
  logic   r_skid_vld;

  entry_t w_in_ent;
  logic   w_acc;
  logic   w_xfer;
  logic   w_main_free;

  assign w_in_ent    = {ctrl_in, data_in};

  // Skid full means the next entry would have nowhere to go; gating with
  // reset keeps the upstream from handing over entries while in reset.
  assign in_ready    = ~r_skid_vld & reset;
  assign w_acc       = in_valid & in_ready;
  assign w_xfer      = r_main_vld & out_ready;
  // Main can take a new entry this edge if it is empty or is being drained.
  assign w_main_free = ~r_main_vld | w_xfer;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (flush) begin
      // Any entry accepted this cycle is dropped along with the held ones.
      r_main_vld  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_main.ctrl <= '0;
      if (CLR_DATA_ON_FLUSH != 0)
        r_main.data <= '0;
    end else if (w_main_free) begin
      if (r_skid_vld) begin
        // Older skid entry goes first; in_ready was low so no input competes.
        r_main     <= r_skid;
        r_main_vld <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (w_acc) begin
        r_main     <= w_in_ent;
        r_main_vld <= 1'b1;
      end else begin
        // Going empty: kill control so downstream sees a bubble, keep data.
        r_main_vld  <= 1'b0;
        r_main.ctrl <= '0;
      end
    end else if (w_acc) begin
      // Main stalled and full: park the new entry in the skid slot.
      r_skid     <= w_in_ent;
      r_skid_vld <= 1'b1;
    end
  end

  assign out_valid = r_main_vld;
  assign ctrl_out  = r_main.ctrl;
  assign data_out  = r_main.data;
  // Skid is only ever filled behind a valid main entry.
  assign occ       = r_skid_vld ? 2'd2 : {1'b0, r_main_vld};

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [8:0]  ctrl_in;
  logic [31:0] data_in;

  logic        rdy0, ov0, rdy1, ov1;
  logic [8:0]  co0, co1;
  logic [31:0] do0, do1;
  logic [1:0]  occ0, occ1;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(9), .CLR_DATA_ON_FLUSH(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .ctrl_in(ctrl_in), .data_in(data_in),
    .out_valid(ov0), .out_ready(out_ready), .ctrl_out(co0), .data_out(do0),
    .occ(occ0));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(9), .CLR_DATA_ON_FLUSH(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .ctrl_in(ctrl_in), .data_in(data_in),
    .out_valid(ov1), .out_ready(out_ready), .ctrl_out(co1), .data_out(do1),
    .occ(occ1));

  // Reference: the stage is a FIFO of at most two entries, plus the last
  // presented data word for each flush flavour.
  typedef struct {
    logic [8:0]  c;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] last0, last1;
  bit          known = 1'b0;
  logic [31:0] seen[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  task automatic step(input bit rst_n, input bit fl, input bit iv,
                      input logic [8:0] c, input logic [31:0] d, input bit ordy);
    bit         e_rdy, e_ov, acc, xfer;
    logic [8:0] e_c;
    ent_t       e;
    reset = rst_n; flush = fl; in_valid = iv; ctrl_in = c; data_in = d; out_ready = ordy;
    #1;
    e_rdy = rst_n && (q.size() < 2);
    e_ov  = q.size() > 0;
    e_c   = e_ov ? q[0].c : 9'h0;
    if (known || !rst_n) begin
      chk("in_ready0", rdy0, e_rdy);
      chk("in_ready1", rdy1, e_rdy);
    end
    if (known) begin
      chk("out_valid0", ov0, e_ov);
      chk("out_valid1", ov1, e_ov);
      chk("ctrl_out0", co0, e_c);
      chk("ctrl_out1", co1, e_c);
      chk("data_out0", do0, last0);
      chk("data_out1", do1, last1);
      chk("occ0", occ0, q.size());
      chk("occ1", occ1, q.size());
    end
    acc  = iv && e_rdy;
    xfer = known && e_ov && ordy;
    if (xfer) seen.push_back(do0);
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); last0 = '0; last1 = '0; known = 1'b1;
    end else if (fl) begin
      q.delete(); last1 = '0;
    end else begin
      if (xfer) void'(q.pop_front());
      if (acc) begin e.c = c; e.d = d; q.push_back(e); end
      if (q.size() > 0) begin last0 = q[0].d; last1 = q[0].d; end
    end
    @(negedge clk);
  endtask

  initial begin
    // reset and release
    step(0, 0, 0, 9'h0, 32'h0, 0);
    step(0, 1, 1, 9'h1, 32'h5, 1);
    step(1, 0, 0, 9'h0, 32'h0, 1);

    // streaming 1..8 with out_ready held high
    seen.delete();
    for (int i = 1; i <= 8; i++) step(1, 0, 1, 9'(i), 32'(i), 1);
    step(1, 0, 0, 9'h0, 32'h0, 1);
    chk("stream_cnt", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) chk("stream_data", seen[i], i + 1);

    // stall fill: A accepted, B to skid, C held upstream, then release
    seen.delete();
    step(1, 0, 1, 9'h01, 32'h11, 0);
    step(1, 0, 1, 9'h02, 32'h22, 0);
    step(1, 0, 1, 9'h03, 32'h33, 0);
    chk("stall_rdy", rdy0, 0);
    chk("stall_occ", occ0, 2);
    step(1, 0, 1, 9'h03, 32'h33, 1);
    step(1, 0, 1, 9'h03, 32'h33, 1);
    step(1, 0, 0, 9'h00, 32'h00, 1);
    chk("stall_cnt", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("stall_A", seen[0], 32'h11);
      chk("stall_B", seen[1], 32'h22);
      chk("stall_C", seen[2], 32'h33);
    end

    // flush with two entries held
    step(1, 0, 1, 9'h1FF, 32'hAA, 0);
    step(1, 0, 1, 9'h1FF, 32'hBB, 0);
    step(1, 1, 0, 9'h000, 32'h00, 0);
    chk("flush_ov", ov0, 0);
    chk("flush_ctrl", co0, 0);
    chk("flush_occ", occ0, 0);
    chk("flush_rdy", rdy0, 1);
    chk("flush_hold", do0, 32'hAA);
    chk("flush_clr", do1, 32'h0);

    // flush coinciding with accept of D; E must follow in one cycle
    seen.delete();
    step(1, 1, 1, 9'h04, 32'h44, 1);
    step(1, 0, 1, 9'h05, 32'h55, 1);
    chk("flushacc_E_ov", ov0, 1);
    chk("flushacc_E_d", do0, 32'h55);
    step(1, 0, 0, 9'h00, 32'h00, 1);
    chk("flushacc_cnt", seen.size(), 1);
    if (seen.size() == 1) chk("flushacc_E", seen[0], 32'h55);

    // reset while full with out_ready toggling
    step(1, 0, 1, 9'h06, 32'h66, 0);
    step(1, 0, 1, 9'h07, 32'h77, 0);
    step(0, 0, 1, 9'h08, 32'h88, 1);
    chk("rst_ov", ov0, 0);
    chk("rst_data", do0, 0);
    chk("rst_rdy", rdy0, 0);
    step(0, 1, 1, 9'h09, 32'h99, 0);
    step(1, 0, 0, 9'h00, 32'h00, 1);

    // random traffic against the reference
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) < 7),
           9'($urandom),
           $urandom,
           ($urandom_range(0, 9) < 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
